// File: rtl/kamacore_dmem_pkg.sv
// -----------------------------------------------------------------------------
// kamacore_dmem_pkg
// Shared types and constants for the data-memory controller.
//   CPU_WIDTH : datapath / byte-address width
//   size_e    : access size encoding used on core_size (3 decodes as word)
//   state_e   : controller state (IDLE, or second half of a sub-word store)
// -----------------------------------------------------------------------------
package kamacore_dmem_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } state_e;

endpackage

// File: rtl/kamacore_dmem_lane.sv
// -----------------------------------------------------------------------------
// kamacore_dmem_lane
// Purely combinational byte-lane unit.
//   size_i     : access size (byte / half / word, 3 = word)
//   addr_lo_i  : byte offset within the word
//   unsigned_i : zero-extend sub-word loads when 1, sign-extend when 0
//   rdata_i    : word read from memory (load path)
//   old_i      : word captured for read-modify-write (store path)
//   wdata_i    : LSB-aligned store data
//   load_o     : extracted and extended load value
//   merge_o    : old_i with the addressed lanes replaced by store data
// -----------------------------------------------------------------------------
module kamacore_dmem_lane
    import kamacore_dmem_pkg::*;
(
    input  logic [1:0]           size_i,
    input  logic [1:0]           addr_lo_i,
    input  logic                 unsigned_i,
    input  logic [CPU_WIDTH-1:0] rdata_i,
    input  logic [CPU_WIDTH-1:0] old_i,
    input  logic [CPU_WIDTH-1:0] wdata_i,
    output logic [CPU_WIDTH-1:0] load_o,
    output logic [CPU_WIDTH-1:0] merge_o
);

    localparam int NB = CPU_WIDTH / 8;

    logic        is_byte;
    logic        is_half;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign is_byte  = (size_i == SIZE_BYTE);
    assign is_half  = (size_i == SIZE_HALF);
    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        load_o = rdata_i;
        if (is_byte) begin
            load_o = unsigned_i ? {{(CPU_WIDTH-8){1'b0}}, byte_sel}
                                : {{(CPU_WIDTH-8){byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            load_o = unsigned_i ? {{(CPU_WIDTH-16){1'b0}}, half_sel}
                                : {{(CPU_WIDTH-16){half_sel[15]}}, half_sel};
        end
    end

    // Store data is replicated across the word so each lane simply picks its
    // own byte; the lane enable decides whether it replaces the old byte.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       be;
            logic [7:0] src;
            assign be  = is_byte ? (addr_lo_i == LANE)
                       : is_half ? (addr_lo_i[1] == LANE[1])
                       : 1'b1;
            assign src = is_byte ? wdata_i[7:0]
                       : is_half ? wdata_i[8*(gi%2) +: 8]
                       : wdata_i[8*gi +: 8];
            assign merge_o[8*gi +: 8] = be ? src : old_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/kamacore_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// kamacore_dmem_ctrl
// Arbiter/controller for the single-port, async-read data memory.
//   clk, rst            : clock, synchronous active-low reset
//   core_*              : MEM-stage load/store port (byte address, sized)
//   dma_*               : word-only secondary port (word address)
//   mem_we/mem_a/mem_di : memory write enable, word address, write data
//   mem_spo             : memory asynchronous read data for mem_a
// Core wins arbitration unless the dma port has been refused STARVE_LIMIT
// consecutive cycles. Sub-word stores take two cycles (read, then merged
// write) and hold the memory for the core across both.
// -----------------------------------------------------------------------------
module kamacore_dmem_ctrl #(
    parameter int CPU_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [1:0]            core_size,
    input  logic                  core_unsigned,
    input  logic [CPU_WIDTH-1:0]  core_addr,
    input  logic [CPU_WIDTH-1:0]  core_wdata,
    output logic [CPU_WIDTH-1:0]  core_rdata,
    output logic                  core_ready,
    output logic                  core_misaligned,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [CPU_WIDTH-1:0]  dma_wdata,
    output logic [CPU_WIDTH-1:0]  dma_rdata,
    output logic                  dma_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [CPU_WIDTH-1:0]  mem_di,
    input  logic [CPU_WIDTH-1:0]  mem_spo
);
    import kamacore_dmem_pkg::*;

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic [CPU_WIDTH-1:0] rmw_buf_q, rmw_buf_d;

    logic [ADDR_WIDTH-1:0] core_waddr;
    logic                  is_sub_word;
    logic                  core_mis;
    logic                  in_idle;
    logic                  dma_grant;
    logic                  core_grant;
    logic [CPU_WIDTH-1:0]  load_data;
    logic [CPU_WIDTH-1:0]  merge_data;
    logic                  unused_addr_bits;

    assign core_waddr       = core_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^core_addr[CPU_WIDTH-1:ADDR_WIDTH+2];
    assign is_sub_word      = (core_size == SIZE_BYTE) || (core_size == SIZE_HALF);
    assign core_mis         = ((core_size == SIZE_HALF) && core_addr[0])
                            || (!is_sub_word && (core_addr[1:0] != 2'b00));
    assign in_idle          = (state_q == ST_IDLE);
    // dma only competes against an actual core request; an idle core never
    // blocks it.
    assign dma_grant        = rst && in_idle && dma_req
                            && (!core_req || (starve_cnt_q == STARVE_MAX));
    assign core_grant       = rst && in_idle && core_req && !dma_grant;

    kamacore_dmem_lane u_lane (
        .size_i     (core_size),
        .addr_lo_i  (core_addr[1:0]),
        .unsigned_i (core_unsigned),
        .rdata_i    (mem_spo),
        .old_i      (rmw_buf_q),
        .wdata_i    (core_wdata),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    always_comb begin
        state_d         = state_q;
        starve_cnt_d    = starve_cnt_q;
        rmw_buf_d       = rmw_buf_q;
        mem_we          = 1'b0;
        mem_a           = core_waddr;
        mem_di          = '0;
        core_ready      = 1'b0;
        core_misaligned = 1'b0;
        core_rdata      = '0;
        dma_ready       = 1'b0;
        dma_rdata       = '0;

        // Everything stays quiet while reset is asserted, which also drops
        // any merged write that was pending in RMW_WRITE.
        if (rst) begin
            if (dma_grant) begin
                mem_a     = dma_addr;
                mem_we    = dma_we;
                mem_di    = dma_wdata;
                dma_ready = 1'b1;
                dma_rdata = dma_we ? '0 : mem_spo;
            end else if (core_grant) begin
                if (core_mis) begin
                    core_ready      = 1'b1;
                    core_misaligned = 1'b1;
                end else if (!core_we) begin
                    core_ready = 1'b1;
                    core_rdata = load_data;
                end else if (!is_sub_word) begin
                    core_ready = 1'b1;
                    mem_we     = 1'b1;
                    mem_di     = core_wdata;
                end else begin
                    rmw_buf_d = mem_spo;
                    state_d   = ST_RMW_WRITE;
                end
            end else if (state_q == ST_RMW_WRITE) begin
                mem_we     = 1'b1;
                mem_di     = merge_data;
                core_ready = 1'b1;
                state_d    = ST_IDLE;
            end

            // A misaligned core access never touches memory, so it is not
            // charged against the waiting dma request.
            if (!dma_req || dma_grant) begin
                starve_cnt_d = '0;
            end else if (core_grant && core_mis) begin
                starve_cnt_d = starve_cnt_q;
            end else if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            rmw_buf_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rmw_buf_q    <= rmw_buf_d;
        end
    end

endmodule

// File: tb/tb_kamacore_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kamacore_dmem_ctrl
// Self-checking bench: directed scenarios followed by randomized traffic on
// both ports, checked against a behavioural model (expected memory image,
// dma starvation count, pending sub-word store).
// -----------------------------------------------------------------------------
module tb_kamacore_dmem_ctrl;

    localparam int AW    = 10;
    localparam int LIMIT = 4;
    localparam int NW    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_unsigned;
    logic [1:0]  core_size;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_ready, core_misaligned;
    logic        dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic        dma_ready;
    logic        mem_we;
    logic [AW-1:0] mem_a;
    logic [31:0] mem_di, mem_spo;

    logic [31:0] mem_array [0:(1<<AW)-1];
    logic [31:0] ref_mem   [0:(1<<AW)-1];
    logic        bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0] bd_data;

    int tests = 0;
    int fails = 0;

    kamacore_dmem_ctrl #(.CPU_WIDTH(32), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ready(core_ready), .core_misaligned(core_misaligned),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    // Memory: asynchronous read, synchronous write; backdoor port for preload.
    assign mem_spo = mem_array[mem_a];
    always @(posedge clk) begin
        if (mem_we)     mem_array[mem_a]   <= mem_di;
        else if (bd_we) mem_array[bd_addr] <= bd_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        core_req = 1'b0; core_we = 1'b0; core_size = 2'd2; core_unsigned = 1'b0;
        core_addr = 32'h0; core_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = 32'h0;
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = AW'(w); bd_data = d;
        tick;
        bd_we = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic core_drive(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] d);
        core_req = 1'b1; core_we = we; core_size = sz; core_unsigned = uns;
        core_addr = a; core_wdata = d;
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic test_reset;
        idle_inputs;
        rst = 1'b0;
        core_req = 1'b1; dma_req = 1'b1;
        tick; tick;
        @(negedge clk);
        tests++; if (core_ready !== 1'b0) begin fails++; $display("FAIL reset_core_ready got %0b want 0", core_ready); end
        tests++; if (dma_ready !== 1'b0) begin fails++; $display("FAIL reset_dma_ready got %0b want 0", dma_ready); end
        tests++; if (core_misaligned !== 1'b0) begin fails++; $display("FAIL reset_misaligned got %0b want 0", core_misaligned); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
        tests++; if (core_rdata !== 32'h0) begin fails++; $display("FAIL reset_core_rdata got %h want 0", core_rdata); end
        tests++; if (dma_rdata !== 32'h0) begin fails++; $display("FAIL reset_dma_rdata got %h want 0", dma_rdata); end
        idle_inputs;
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_load;
        preload(16, 32'h11223344);
        core_drive(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
        @(negedge clk);
        tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL load_byte_ready got %0b want 1", core_ready); end
        tests++; if (core_rdata !== 32'h00000033) begin fails++; $display("FAIL load_byte_data got %h want 00000033", core_rdata); end
        tick; idle_inputs;
        preload(16, 32'h80005678);
        core_drive(1'b0, 2'd1, 1'b0, 32'h42, 32'h0);
        @(negedge clk);
        tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL load_half_ready got %0b want 1", core_ready); end
        tests++; if (core_rdata !== 32'hFFFF8000) begin fails++; $display("FAIL load_half_signed got %h want ffff8000", core_rdata); end
        tick;
        core_unsigned = 1'b1;
        @(negedge clk);
        tests++; if (core_rdata !== 32'h00008000) begin fails++; $display("FAIL load_half_unsigned got %h want 00008000", core_rdata); end
        tick; idle_inputs;
    endtask

    task automatic test_store_byte;
        preload(16, 32'h11223344);
        core_drive(1'b1, 2'd0, 1'b0, 32'h43, 32'h123456AB);
        @(negedge clk);
        tests++; if (core_ready !== 1'b0) begin fails++; $display("FAIL sb_cycle1_ready got %0b want 0", core_ready); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL sb_cycle1_we got %0b want 0", mem_we); end
        tick;
        @(negedge clk);
        tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL sb_cycle2_ready got %0b want 1", core_ready); end
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL sb_cycle2_we got %0b want 1", mem_we); end
        tick; idle_inputs;
        tests++; if (mem_array[16] !== 32'hAB223344) begin fails++; $display("FAIL sb_result got %h want ab223344", mem_array[16]); end
    endtask

    task automatic test_starvation;
        preload(16, 32'h11223344);
        preload(5, 32'hCAFE0005);
        core_drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'(5);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                tests++; if (dma_ready !== 1'b1) begin fails++; $display("FAIL starve_dma_ready c%0d got %0b want 1", i, dma_ready); end
                tests++; if (core_ready !== 1'b0) begin fails++; $display("FAIL starve_core_ready c%0d got %0b want 0", i, core_ready); end
                tests++; if (dma_rdata !== 32'hCAFE0005) begin fails++; $display("FAIL starve_dma_rdata got %h want cafe0005", dma_rdata); end
            end else begin
                tests++; if (dma_ready !== 1'b0) begin fails++; $display("FAIL starve_dma_ready c%0d got %0b want 0", i, dma_ready); end
                tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL starve_core_ready c%0d got %0b want 1", i, core_ready); end
                tests++; if (core_rdata !== 32'h11223344) begin fails++; $display("FAIL starve_core_rdata c%0d got %h want 11223344", i, core_rdata); end
            end
            tick;
        end
        idle_inputs;
        tick;
    endtask

    task automatic test_rmw_lock;
        preload(16, 32'h11223344);
        core_drive(1'b1, 2'd1, 1'b0, 32'h42, 32'h1234BEEF);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'(16);
        @(negedge clk);
        tests++; if (core_ready !== 1'b0 || dma_ready !== 1'b0) begin fails++; $display("FAIL lock_c1 core_ready %0b dma_ready %0b want 0 0", core_ready, dma_ready); end
        tick;
        @(negedge clk);
        tests++; if (core_ready !== 1'b1 || dma_ready !== 1'b0) begin fails++; $display("FAIL lock_c2 core_ready %0b dma_ready %0b want 1 0", core_ready, dma_ready); end
        tick;
        core_req = 1'b0;
        @(negedge clk);
        tests++; if (dma_ready !== 1'b1) begin fails++; $display("FAIL lock_c3_dma_ready got %0b want 1", dma_ready); end
        tests++; if (dma_rdata !== 32'hBEEF3344) begin fails++; $display("FAIL lock_c3_dma_rdata got %h want beef3344", dma_rdata); end
        tick; idle_inputs;
    endtask

    task automatic test_misaligned;
        preload(16, 32'h11223344);
        core_drive(1'b1, 2'd2, 1'b0, 32'h42, 32'hDEADBEEF);
        @(negedge clk);
        tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL mis_word_ready got %0b want 1", core_ready); end
        tests++; if (core_misaligned !== 1'b1) begin fails++; $display("FAIL mis_word_flag got %0b want 1", core_misaligned); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL mis_word_we got %0b want 0", mem_we); end
        tick;
        core_drive(1'b0, 2'd1, 1'b0, 32'h41, 32'h0);
        @(negedge clk);
        tests++; if (core_misaligned !== 1'b1) begin fails++; $display("FAIL mis_half_flag got %0b want 1", core_misaligned); end
        tick; idle_inputs;
        tests++; if (mem_array[16] !== 32'h11223344) begin fails++; $display("FAIL mis_mem got %h want 11223344", mem_array[16]); end
    endtask

    task automatic test_reset_in_rmw;
        preload(16, 32'h11223344);
        core_drive(1'b1, 2'd0, 1'b0, 32'h40, 32'h00000055);
        @(negedge clk);
        tests++; if (core_ready !== 1'b0) begin fails++; $display("FAIL rrmw_c1_ready got %0b want 0", core_ready); end
        tick;
        rst = 1'b0;
        dma_req = 1'b1;
        @(negedge clk);
        tests++; if (core_ready !== 1'b0 || dma_ready !== 1'b0) begin fails++; $display("FAIL rrmw_readies core %0b dma %0b want 0 0", core_ready, dma_ready); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rrmw_mem_we got %0b want 0", mem_we); end
        tick;
        rst = 1'b1;
        idle_inputs;
        core_drive(1'b0, 2'd0, 1'b1, 32'h40, 32'h0);
        @(negedge clk);
        tests++; if (core_ready !== 1'b1) begin fails++; $display("FAIL rrmw_next_ready got %0b want 1", core_ready); end
        tests++; if (core_rdata !== 32'h00000044) begin fails++; $display("FAIL rrmw_next_rdata got %h want 00000044", core_rdata); end
        tests++; if (mem_array[16] !== 32'h11223344) begin fails++; $display("FAIL rrmw_mem got %h want 11223344", mem_array[16]); end
        tick; idle_inputs;
    endtask

    task automatic test_random;
        bit          hold = 1'b0;
        bit          m_rmw = 1'b0;
        int          m_starve = 0;
        logic [9:0]  wa;
        logic [1:0]  off, sz;
        bit          mis, e_cr, e_dr, e_we, e_mis, chk_crd, chk_drd, pend;
        logic [31:0] e_crd, e_drd, mask, pend_data;
        int          pend_addr;
        for (int w = 0; w < NW; w++) preload(w, $urandom);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!hold) begin
                core_req      = ($urandom_range(0, 3) != 0);
                core_we       = 1'($urandom_range(0, 1));
                core_size     = 2'($urandom_range(0, 3));
                core_unsigned = 1'($urandom_range(0, 1));
                off = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1)
                    off = (core_size == 2'd0) ? off : (core_size == 2'd1) ? {off[1], 1'b0} : 2'b00;
                core_addr  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, NW-1)) << 2) | 32'(off);
                core_wdata = $urandom;
            end
            dma_req   = ($urandom_range(0, 2) == 0);
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = AW'($urandom_range(0, NW-1));
            dma_wdata = $urandom;
            @(negedge clk);
            wa  = core_addr[11:2];
            off = core_addr[1:0];
            sz  = (core_size == 2'd3) ? 2'd2 : core_size;
            mis = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'b00);
            e_cr = 0; e_dr = 0; e_we = 0; e_mis = 0; chk_crd = 0; chk_drd = 0; pend = 0;
            e_crd = 32'h0; e_drd = 32'h0; pend_data = 32'h0; pend_addr = 0;
            if (m_rmw) begin
                e_cr = 1; e_we = 1; m_rmw = 0;
                mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                pend = 1; pend_addr = int'(wa);
                pend_data = (ref_mem[wa] & ~mask) | ((core_wdata << (8 * off)) & mask);
                m_starve = dma_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end else if (dma_req && (!core_req || m_starve == LIMIT)) begin
                e_dr = 1; m_starve = 0;
                if (dma_we) begin
                    e_we = 1; pend = 1; pend_addr = int'(dma_addr); pend_data = dma_wdata;
                end else begin
                    chk_drd = 1; e_drd = ref_mem[dma_addr];
                end
            end else if (core_req) begin
                if (mis) begin
                    e_cr = 1; e_mis = 1;
                    if (!dma_req) m_starve = 0;
                end else begin
                    if (!core_we) begin
                        e_cr = 1; chk_crd = 1; e_crd = exp_load(ref_mem[wa], sz, off, core_unsigned);
                    end else if (sz == 2'd2) begin
                        e_cr = 1; e_we = 1; pend = 1; pend_addr = int'(wa); pend_data = core_wdata;
                    end else begin
                        m_rmw = 1;
                    end
                    m_starve = dma_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                end
            end else begin
                m_starve = 0;
            end
            tests++; if (core_ready !== e_cr) begin fails++; $display("FAIL rnd_core_ready cyc %0d got %0b want %0b", cyc, core_ready, e_cr); end
            tests++; if (dma_ready !== e_dr) begin fails++; $display("FAIL rnd_dma_ready cyc %0d got %0b want %0b", cyc, dma_ready, e_dr); end
            tests++; if (mem_we !== e_we) begin fails++; $display("FAIL rnd_mem_we cyc %0d got %0b want %0b", cyc, mem_we, e_we); end
            if (e_cr) begin
                tests++; if (core_misaligned !== e_mis) begin fails++; $display("FAIL rnd_misaligned cyc %0d got %0b want %0b", cyc, core_misaligned, e_mis); end
            end
            if (chk_crd) begin
                tests++; if (core_rdata !== e_crd) begin fails++; $display("FAIL rnd_core_rdata cyc %0d got %h want %h", cyc, core_rdata, e_crd); end
            end
            if (chk_drd) begin
                tests++; if (dma_rdata !== e_drd) begin fails++; $display("FAIL rnd_dma_rdata cyc %0d got %h want %h", cyc, dma_rdata, e_drd); end
            end
            if (pend) ref_mem[pend_addr] = pend_data;
            hold = core_req && !e_cr;
            tick;
        end
        idle_inputs;
        tick;
        for (int w = 0; w < NW; w++) begin
            tests++; if (mem_array[w] !== ref_mem[w]) begin fails++; $display("FAIL rnd_mem word %0d got %h want %h", w, mem_array[w], ref_mem[w]); end
        end
    endtask

    initial begin
        bd_we = 1'b0; bd_addr = '0; bd_data = 32'h0;
        rst = 1'b0;
        idle_inputs;
        test_reset;
        test_load;
        test_store_byte;
        test_starvation;
        test_rmw_lock;
        test_misaligned;
        test_reset_in_rmw;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
